// File: rtl/bin2bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter (double dabble, one bit per cycle).
// Optional macro BIN2BCD_OVF_EN adds an ovf output and clamps out-of-range results to 999999.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] value,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bcd5,
    output logic [3:0]  bcd4,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0
`ifdef BIN2BCD_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam int DATA_W = 20;
    localparam int ACC_W  = 28;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nx;
    logic [4:0]          cnt;
    logic                accept, finish;
    logic [DATA_W-1:0]   sr, sr_nx;
    logic [ACC_W-1:0]    acc, acc_adj, acc_nx;
    logic [23:0]         digits;

    function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < 7; i++) begin
            if (a[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 5'd19) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nx;
            if (accept || finish)
                cnt <= 5'd0;
            else if (state == SHIFT)
                cnt <= cnt + 5'd1;
        end
    end

    // One double-dabble step: adjust nibbles, then shift {acc, sr} left by one.
    always_comb begin
        acc_adj = add3(acc);
        acc_nx  = (acc_adj << 1) | {{(ACC_W-1){1'b0}}, sr[DATA_W-1]};
        sr_nx   = sr << 1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sr  <= value;
            acc <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr_nx;
            acc <= acc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            digits <= 24'd0;
`ifdef BIN2BCD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= finish;
            if (finish) begin
`ifdef BIN2BCD_OVF_EN
                if (acc_nx[27:24] != 4'd0) begin
                    digits <= 24'h999999;
                    ovf    <= 1'b1;
                end else begin
                    digits <= acc_nx[23:0];
                    ovf    <= 1'b0;
                end
`else
                digits <= acc_nx[23:0];
`endif
            end
        end
    end

    assign busy = (state == SHIFT);
    assign bcd0 = digits[3:0];
    assign bcd1 = digits[7:4];
    assign bcd2 = digits[11:8];
    assign bcd3 = digits[15:12];
    assign bcd4 = digits[19:16];
    assign bcd5 = digits[23:20];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, hand-written corner sequences, random vs. decimal model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [19:0] value;
    logic        busy, done;
    logic [3:0]  bcd5, bcd4, bcd3, bcd2, bcd1, bcd0;
`ifdef BIN2BCD_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int failures = 0;
    logic [23:0] last_digits;
    logic        last_ovf;

    bin2bcd_seq dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done),
        .bcd5(bcd5), .bcd4(bcd4), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0)
`ifdef BIN2BCD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] value;
        logic [23:0] exp_digits;
        logic        exp_ovf;
    } vec_t;

    function automatic logic [23:0] get_digits();
        return {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
    endfunction

    function automatic logic get_ovf();
`ifdef BIN2BCD_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Decimal reference: plain integer arithmetic on the operand.
    function automatic logic [24:0] model(input logic [19:0] v);
        int r;
        logic [23:0] d;
`ifdef BIN2BCD_OVF_EN
        if (v > 20'd999999) return {1'b1, 24'h999999};
`endif
        r = int'(v) % 1000000;
        d = '0;
        for (int i = 0; i < 6; i++) begin
            d[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {1'b0, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue start from IDLE (or the done cycle), then follow the conversion to its done pulse.
    // Returns positioned in the done cycle. poke_cycle>0 raises start with value 7 at that busy cycle.
    task automatic convert(input logic [19:0] v, input logic [23:0] exp_d, input logic exp_o,
                           input int poke_cycle, input string name);
        start = 1'b1;
        value = v;
        step();
        start = 1'b0;
        value = $urandom_range(0, 20'hFFFFF);
        chk({name, "_busy_start"}, busy, 1);
        for (int i = 1; i <= 20; i++) begin
            if (i == poke_cycle) begin
                start = 1'b1;
                value = 20'd7;
            end
            step();
            start = 1'b0;
            if (i < 20) begin
                if (done !== 1'b0 || busy !== 1'b1 || get_digits() !== last_digits) begin
                    chk({name, "_during_shift"}, {busy, done, get_digits()}, {1'b1, 1'b0, last_digits});
                end
            end
        end
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_digits"}, get_digits(), exp_d);
        chk({name, "_ovf"}, get_ovf(), exp_o);
        last_digits = exp_d;
        last_ovf    = exp_o;
    endtask

    vec_t vecs[6];
    logic [24:0] m;

    initial begin
        rst = 1'b1; start = 1'b0; value = 20'd0;
        last_digits = 24'd0; last_ovf = 1'b0;
        step(); step();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_digits", get_digits(), 0);
        chk("reset_ovf", get_ovf(), 0);
        rst = 1'b0;
        step();

        vecs[0] = '{20'd146,     24'h000146, 1'b0};
        vecs[1] = '{20'd0,       24'h000000, 1'b0};
        vecs[2] = '{20'd999999,  24'h999999, 1'b0};
`ifdef BIN2BCD_OVF_EN
        vecs[3] = '{20'd1048575, 24'h999999, 1'b1};
`else
        vecs[3] = '{20'd1048575, 24'h048575, 1'b0};
`endif
        vecs[4] = '{20'd12345,   24'h012345, 1'b0};
        vecs[5] = '{20'd1000000, 24'h000000, 1'b0};
`ifdef BIN2BCD_OVF_EN
        vecs[5].exp_digits = 24'h999999;
        vecs[5].exp_ovf    = 1'b1;
`endif
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].value, vecs[i].exp_digits, vecs[i].exp_ovf, 0, $sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_hold", i), get_digits(), vecs[i].exp_digits);
        end

        // Back-to-back: start raised in the done cycle is accepted.
        convert(20'd0, 24'h000000, 1'b0, 0, "b2b_first");
        convert(20'd999999, 24'h999999, 1'b0, 0, "b2b_second");
        step();
        chk("b2b_done_pulse", done, 0);

        // Start while busy is ignored; operand changes during SHIFT do not matter.
        convert(20'd500000, 24'h500000, 1'b0, 5, "ignore_busy");
        for (int i = 0; i < 25; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) chk("ignore_no_second", {busy, done}, 2'b00);
        end
        chk("ignore_idle", busy, 0);
        chk("ignore_hold", get_digits(), 24'h500000);

        // Reset mid-conversion aborts with cleared outputs.
        start = 1'b1; value = 20'd123456;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_digits", get_digits(), 0);
        chk("abort_ovf", get_ovf(), 0);
        last_digits = 24'd0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done !== 1'b0) chk("abort_no_done", done, 0);
        end
        convert(20'd654321, 24'h654321, 1'b0, 0, "after_abort");
        step();

        // Reset takes priority over start.
        rst = 1'b1; start = 1'b1; value = 20'd42;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_digits", get_digits(), 0);
        last_digits = 24'd0;
        step();

        // Random operands against the decimal model.
        for (int i = 0; i < 20; i++) begin
            logic [19:0] rv;
            rv = 20'($urandom_range(0, 20'hFFFFF));
            m = model(rv);
            convert(rv, m[23:0], m[24], 0, $sformatf("rand%0d_%0d", i, rv));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port start, input, 1 bit: request to convert value; sampled on each rising edge.
REQ-004 The block SHALL have the port value, input, 20 bits: unsigned binary operand; sampled only on the accepting edge.
REQ-005 The block SHALL have the port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 The block SHALL have the port done, output, 1 bit: one-cycle pulse when new digits are valid.
REQ-007 The block SHALL have the ports bcd5..bcd0, output, 4 bits each: decimal digits, bcd5 = most significant (100000s) and bcd0 = least significant (units); each feeds one seven-seg digit decoder.
REQ-008 The block SHALL have the port ovf, output, 1 bit, present only when BIN2BCD_OVF_EN is defined: operand exceeded 999999.

Function
REQ-009 The block SHALL use two states, IDLE and SHIFT, with a 5-bit iteration counter.
REQ-010 In IDLE, start=1 SHALL be accepted on that edge: latch value into a 20-bit shift register, clear the 28-bit (7-digit) BCD accumulator and counter, and go to SHIFT; busy SHALL go high after this edge.
REQ-011 Each SHIFT cycle SHALL add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by 1 (double dabble), and increment the counter.
REQ-012 On the 20th SHIFT edge, the block SHALL load bcd5..bcd0 from the final accumulator low 6 nibbles, pulse done=1 for exactly one cycle, drop busy, and return to IDLE.
REQ-013 Latency SHALL be fixed: done high in the 20th cycle after the accepting edge, independent of value.
REQ-014 start while busy=1 SHALL be ignored, with no queuing; value changes during SHIFT SHALL have no effect.
REQ-015 start=1 in the cycle done=1 SHALL be accepted; back-to-back throughput SHALL be one conversion per 20 cycles.
REQ-016 bcd5..bcd0 (and ovf) SHALL hold the last result until the next done; they SHALL NOT change during SHIFT.
REQ-017 For value > 999999 without the macro, outputs SHALL be the low 6 decimal digits (value mod 1000000); the 7th accumulator digit is discarded.

Reset
REQ-018 rst=1 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, bcd5..bcd0=0, and ovf=0; rst SHALL take priority over start.
REQ-019 rst during SHIFT SHALL abort the conversion with no done pulse, and outputs SHALL clear to 0.

Configuration
REQ-020 With BIN2BCD_OVF_EN defined: ovf port present; on done, if the 7th accumulator digit != 0, bcd5..bcd0 SHALL all be 9 and ovf=1; otherwise ovf=0 with normal digits.
REQ-021 Without BIN2BCD_OVF_EN: no ovf port; behaviour per REQ-017.

Verification
REQ-022 Scenario: rst 2 cycles, start with value=146 -> busy for 20 cycles; done pulse with digits 0,0,0,1,4,6 (bcd5..bcd0).
REQ-023 Scenario: value=0, then value=999999 back-to-back with start in the done cycle -> 0,0,0,0,0,0 then 9,9,9,9,9,9, with done pulses 20 cycles apart.
REQ-024 Scenario: value=1048575 -> without macro 0,4,8,5,7,5; with macro 9,9,9,9,9,9 and ovf=1; next value=12345 -> ovf=0 and 0,1,2,3,4,5.
REQ-025 Scenario: start with value=500000, then start with value=7 at cycle 5 while busy -> single done with 5,0,0,0,0,0; the second start is ignored.
REQ-026 Scenario: start with value=123456, rst at cycle 10 -> no done pulse, outputs 0; a fresh start with value=654321 -> 6,5,4,3,2,1 after 20 cycles.
